// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream helpers.
package hwpe_stream_package;

  typedef enum logic {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } split_sched_state_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                      valid;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     data;
  logic [DATA_WIDTH/8-1:0]   strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_split_sched.sv
// Splits one wide stream into NB_OUT_STREAMS narrow slices; each slice handshakes on its
// own and the input beat is released once every enabled slice has taken its part.
module hwpe_stream_split_sched
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_OUT_STREAMS = 2,
  parameter int unsigned DATA_WIDTH_IN  = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [NB_OUT_STREAMS-1:0] enable_i,
  hwpe_stream_intf_stream.sink      stream_i,
  hwpe_stream_intf_stream.source    stream_o [NB_OUT_STREAMS-1:0],
  output logic                      busy_o,
  output logic [15:0]               beat_cnt_o
);

  localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS;
  localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8;

  split_sched_state_t state_q, state_d;
  logic [NB_OUT_STREAMS-1:0] done_q, done_d;
  logic [NB_OUT_STREAMS-1:0] en_q, en_d;
  logic [15:0]               cnt_q, cnt_d;

  logic [NB_OUT_STREAMS-1:0] act, valid_o, ready_o, fire;
  logic                      complete, in_ready, in_hs;

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : gen_slice
    assign stream_o[i].data  = stream_i.data[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
    assign stream_o[i].strb  = stream_i.strb[i*STRB_WIDTH_OUT +: STRB_WIDTH_OUT];
    assign stream_o[i].valid = valid_o[i];
    assign ready_o[i]        = stream_o[i].ready;
  end

  // The mask is frozen once the first slice of a beat has been delivered.
  always_comb begin
    act      = (state_q == PARTIAL) ? en_q : enable_i;
    valid_o  = {NB_OUT_STREAMS{stream_i.valid & ~clear_i}} & act & ~done_q;
    fire     = valid_o & ready_o;
    complete = &(done_q | fire | ~act);
    in_ready = complete & ~clear_i;
    in_hs    = stream_i.valid & in_ready;
  end

  assign stream_i.ready = in_ready;
  assign busy_o         = (state_q == PARTIAL);
  assign beat_cnt_o     = cnt_q;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = IDLE;
      done_d  = '0;
      cnt_d   = '0;
    end else if (in_hs) begin
      state_d = IDLE;
      done_d  = '0;
      cnt_d   = cnt_q + 16'd1;
    end else if (state_q == IDLE) begin
      if (stream_i.valid && (|fire)) begin
        state_d = PARTIAL;
        done_d  = fire;
        en_d    = enable_i;
      end
    end else begin
      done_d = done_q | fire;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= '0;
      en_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  // Withdrawing the input while a beat is half delivered would corrupt the split.
  a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == PARTIAL) |-> stream_i.valid);

endmodule
